// File: rtl/lab62_soc_accum_ctrl_if.sv
// Avalon-MM slave bus of the switch-accumulate controller, with its interrupt line.
interface lab62_soc_accum_ctrl_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output chipselect, address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/lab62_soc_accum_ctrl.sv
// Switch-accumulate controller: synchronises and debounces the add/clear keys,
// accumulates the switch value on each add press, and exposes the datapath
// state to the Nios II as an Avalon-MM slave with a level interrupt.
module lab62_soc_accum_ctrl #(
    parameter int unsigned SW_W            = 10,
    parameter int unsigned ACC_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  add_key_n,
    input  logic                  clr_key_n,
    input  logic [SW_W-1:0]       sw,
    lab62_soc_accum_ctrl_if.slave bus,
    output logic [ACC_W-1:0]      acc_out
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_ACC    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_e;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [1:0]      add_sync_q;
    logic [1:0]      clr_sync_q;
    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;
    logic [1:0]      fill_q;      // tracks when the key synchronisers hold real samples again
    logic            sync_valid;

    // Two-flop synchronisers for the asynchronous keys and switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_sync_q <= 2'b11;
            clr_sync_q <= 2'b11;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            fill_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; blocking would collapse the chain.
            add_sync_q <= {add_sync_q[0], add_key_n};
            clr_sync_q <= {clr_sync_q[0], clr_key_n};
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            fill_q     <= {fill_q[0], 1'b1};
        end
    end

    assign sync_valid = fill_q[1];

    // ------------------------------------------------------------------
    // Debounce FSMs, index 0 = add key, index 1 = clear key
    // ------------------------------------------------------------------
    db_state_e        state_q [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [1:0]       armed_q;    // key has been seen released since reset
    logic [1:0]       event_q;
    logic [1:0]       key_low;
    logic             add_ev;
    logic             clr_ev;

    assign key_low = {~clr_sync_q[1], ~add_sync_q[1]};
    assign add_ev  = event_q[0];
    assign clr_ev  = event_q[1];

    // Per-key debounce: a level change is accepted after DEBOUNCE_CYCLES stable samples;
    // a press held through reset stays unarmed until the key is seen released.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
            armed_q <= '0;
            event_q <= '0;
        end else begin
            event_q <= '0;
            for (int k = 0; k < 2; k++) begin
                case (state_q[k])
                    RELEASED: begin
                        if (!key_low[k]) begin
                            if (sync_valid) armed_q[k] <= 1'b1;
                        end else if (armed_q[k]) begin
                            state_q[k] <= PRESS_WAIT;
                            cnt_q[k]   <= CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!key_low[k]) begin
                            state_q[k] <= RELEASED;
                        end else if (cnt_q[k] == CNT_LAST) begin
                            state_q[k] <= PRESSED;
                            event_q[k] <= 1'b1;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!key_low[k]) begin
                            state_q[k] <= RELEASE_WAIT;
                            cnt_q[k]   <= CNT_W'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (key_low[k]) begin
                            state_q[k] <= PRESSED;
                        end else if (cnt_q[k] == CNT_LAST) begin
                            state_q[k] <= RELEASED;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                        end
                    end
                    default: state_q[k] <= RELEASED;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and register file
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic [2:0]       status_q;
    logic [2:0]       mask_q;
    logic [15:0]      count_q;

    logic             wr_en;
    logic             rd_en;
    logic [ACC_W:0]   sum;
    logic [2:0]       status_set;
    logic [2:0]       status_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect && bus.write;
    assign rd_en        = bus.chipselect && bus.read;
    assign unused_wdata = ^bus.writedata;

    // Adder, hardware status sets, write-1-to-clear mask and read mux.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        sum        = {1'b0, acc_q} + (ACC_W+1)'(sw_sync_q);
        status_set = '0;
        status_clr = '0;
        rd_mux     = '0;

        status_set[0] = add_ev;
        status_set[1] = clr_ev;
        status_set[2] = add_ev && !clr_ev && sum[ACC_W];

        if (wr_en && bus.address == ADDR_STATUS) status_clr = bus.writedata[2:0];

        case (bus.address)
            ADDR_ACC:    rd_mux = 32'(acc_q);
            ADDR_STATUS: rd_mux = {29'b0, status_q};
            ADDR_MASK:   rd_mux = {29'b0, mask_q};
            ADDR_COUNT:  rd_mux = {16'b0, count_q};
            default:     rd_mux = '0;
        endcase
    end

    // Accumulator, STATUS/MASK/COUNT registers, registered read data and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            status_q     <= '0;
            mask_q       <= '0;
            count_q      <= '0;
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            // CPU load beats a same-cycle key event; clear beats add.
            if (wr_en && bus.address == ADDR_ACC) acc_q <= bus.writedata[ACC_W-1:0];
            else if (clr_ev)                      acc_q <= '0;
            else if (add_ev)                      acc_q <= sum[ACC_W-1:0];

            // Hardware set wins over a same-cycle software clear.
            status_q <= (status_q & ~status_clr) | status_set;

            if (wr_en && bus.address == ADDR_MASK) mask_q <= bus.writedata[2:0];

            if (add_ev)
                count_q <= (wr_en && bus.address == ADDR_COUNT) ? 16'd1 : count_q + 16'd1;
            else if (wr_en && bus.address == ADDR_COUNT)
                count_q <= '0;

            if (rd_en) bus.readdata <= rd_mux;

            bus.irq <= |(status_q & mask_q);
        end
    end

    assign acc_out = acc_q;

endmodule

// File: tb/tb_lab62_soc_accum_ctrl.sv
// Directed bench for lab62_soc_accum_ctrl with DEBOUNCE_CYCLES=4; bus reads go
// through an expected-value queue that is popped when readdata is valid.
module tb_lab62_soc_accum_ctrl;

    localparam int SW_W  = 10;
    localparam int ACC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             add_key_n;
    logic             clr_key_n;
    logic [SW_W-1:0]  sw;
    logic [ACC_W-1:0] acc_out;

    lab62_soc_accum_ctrl_if bus_if ();

    lab62_soc_accum_ctrl #(
        .SW_W            (SW_W),
        .ACC_W           (ACC_W),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .add_key_n (add_key_n),
        .clr_key_n (clr_key_n),
        .sw        (sw),
        .bus       (bus_if.slave),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q [$];

    // Add-event pulse monitor
    int   add_pulses = 0;
    logic add_prev   = 1'b0;
    logic long_pulse = 1'b0;

    always @(negedge clk) begin
        if (dut.add_ev === 1'b1) begin
            add_pulses++;
            if (add_prev === 1'b1) long_pulse = 1'b1;
        end
        add_prev = dut.add_ev;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = addr;
        bus_if.writedata  = data;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = addr;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check(tag, bus_if.readdata, e);
        end
        @(negedge clk);
    endtask

    task automatic press(input bit do_add, input bit do_clr, input int low_cycles, input int high_cycles);
        if (do_add) add_key_n = 1'b0;
        if (do_clr) clr_key_n = 1'b0;
        tick(low_cycles);
        add_key_n = 1'b1;
        clr_key_n = 1'b1;
        tick(high_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] last_rd;

        reset             = 1'b1;
        add_key_n         = 1'b1;
        clr_key_n         = 1'b1;
        sw                = '0;
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.address    = '0;
        bus_if.writedata  = '0;

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(2);
        check("reset_irq", 32'(bus_if.irq), 32'd0);
        check("reset_acc_out", 32'(acc_out), 32'd0);
        check("reset_readdata", bus_if.readdata, 32'd0);
        bus_read(2'd0, 32'd0, "reset_rd_acc");
        bus_read(2'd1, 32'd0, "reset_rd_status");
        bus_read(2'd2, 32'd0, "reset_rd_mask");
        bus_read(2'd3, 32'd0, "reset_rd_count");

        // Two clean add presses of sw=5
        sw = 10'd5;
        press(1'b1, 1'b0, 20, 20);
        press(1'b1, 1'b0, 20, 20);
        check("two_adds_acc_out", 32'(acc_out), 32'd10);
        bus_read(2'd0, 32'd10, "two_adds_rd_acc");
        bus_read(2'd1, 32'd1, "two_adds_rd_status");
        bus_read(2'd3, 32'd2, "two_adds_rd_count");
        check("two_adds_pulses", 32'(add_pulses), 32'd2);
        check("add_pulse_width", 32'(long_pulse), 32'd0);
        check("two_adds_irq_masked", 32'(bus_if.irq), 32'd0);

        // Bouncing key: toggle every 2 cycles, then hold released
        for (int i = 0; i < 15; i++) begin
            add_key_n = ~add_key_n;
            tick(2);
        end
        add_key_n = 1'b1;
        tick(20);
        check("bounce_acc_out", 32'(acc_out), 32'd10);
        check("bounce_pulses", 32'(add_pulses), 32'd2);
        bus_read(2'd3, 32'd2, "bounce_rd_count");

        // Overflow: 0xFFFE + 3 wraps to 0x0001 and sets OVF
        bus_write(2'd0, 32'h0000_FFFE);
        bus_read(2'd0, 32'h0000_FFFE, "ovf_rd_acc_loaded");
        sw = 10'd3;
        press(1'b1, 1'b0, 20, 20);
        check("ovf_acc_out", 32'(acc_out), 32'h0001);
        bus_read(2'd1, 32'd5, "ovf_rd_status");
        bus_read(2'd3, 32'd3, "ovf_rd_count");
        check("ovf_irq_unmasked_off", 32'(bus_if.irq), 32'd0);
        bus_write(2'd2, 32'd4);
        tick(1);
        check("ovf_irq_on", 32'(bus_if.irq), 32'd1);
        bus_read(2'd2, 32'd4, "ovf_rd_mask");
        bus_write(2'd1, 32'd4);
        check("w1c_irq_still_on", 32'(bus_if.irq), 32'd1);
        tick(1);
        check("w1c_irq_off", 32'(bus_if.irq), 32'd0);
        bus_read(2'd1, 32'd1, "w1c_rd_status");

        // Simultaneous add and clear: clear wins, both flags set, COUNT increments
        bus_write(2'd0, 32'h0000_0020);
        press(1'b1, 1'b1, 20, 20);
        check("both_acc_out", 32'(acc_out), 32'd0);
        bus_read(2'd1, 32'd3, "both_rd_status");
        bus_read(2'd3, 32'd4, "both_rd_count");
        check("both_irq", 32'(bus_if.irq), 32'd0);
        check("both_pulses", 32'(add_pulses), 32'd4);

        // COUNT write clears it; readdata then holds while idle
        bus_write(2'd3, 32'h1234_5678);
        bus_read(2'd3, 32'd0, "count_clear_rd");
        bus_read(2'd2, 32'd4, "hold_rd_mask");
        last_rd = 32'd4;
        tick(3);
        check("readdata_hold", bus_if.readdata, last_rd);

        // Reset in the middle of PRESS_WAIT with the key still held
        sw = 10'd7;
        add_key_n = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(20);
        check("midreset_pulses", 32'(add_pulses), 32'd4);
        check("midreset_acc_out", 32'(acc_out), 32'd0);
        bus_read(2'd3, 32'd0, "midreset_rd_count");
        bus_read(2'd1, 32'd0, "midreset_rd_status");
        add_key_n = 1'b1;
        tick(20);
        check("midreset_release_pulses", 32'(add_pulses), 32'd4);
        press(1'b1, 1'b0, 20, 20);
        check("repress_acc_out", 32'(acc_out), 32'd7);
        check("repress_pulses", 32'(add_pulses), 32'd5);
        bus_read(2'd3, 32'd1, "repress_rd_count");
        bus_read(2'd1, 32'd1, "repress_rd_status");
        check("final_pulse_width", 32'(long_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
